// File: rtl/cache_line_xfer.sv
// rtl/cache_line_xfer.sv - critical-word-first line fill / dirty-line evict engine
module cache_line_xfer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WORDS  = 8,
    localparam int IDX_W = $clog2(WORDS),
    localparam int BOFF  = $clog2(DATA_W / 8)
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [IDX_W-1:0]        crit_idx,
    input  logic [WORDS*DATA_W-1:0] line_i,
    input  logic [DATA_W-1:0]       word_i,
    input  logic                    word_vld_i,
    output logic                    word_rdy_o,
    output logic [DATA_W-1:0]       word_o,
    output logic                    word_vld_o,
    input  logic                    word_rdy_i,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [WORDS*DATA_W-1:0] line_o,
    output logic                    full,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_EVICT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-IDX_W-BOFF){1'b1}}, {(IDX_W+BOFF){1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_CNT  = IDX_W'(WORDS - 1);

    logic [1:0]                        state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [IDX_W-1:0]                  cnt_q, cnt_d;
    logic [ADDR_W-1:0]                 base_q, base_d;
    logic [WORDS-1:0][DATA_W-1:0]      line_q, line_d;
    logic                              step;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        line_d  = line_q;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = mode ? S_EVICT : S_FILL;
                    base_d  = base_addr & BASE_MASK;
                    idx_d   = crit_idx;
                    cnt_d   = '0;
                    if (mode) begin
                        line_d = line_i;
                    end
                end
            end
            S_FILL: begin
                if (word_vld_i) begin
                    line_d[idx_q] = word_i;
                    step          = 1'b1;
                end
            end
            S_EVICT: begin
                step = word_rdy_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Index wraps naturally at WORDS since it is exactly IDX_W bits wide.
        if (step) begin
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            line_q  <= line_d;
        end
    end

    logic active;
    assign active     = (state_q == S_FILL) || (state_q == S_EVICT);
    assign busy       = (state_q != S_IDLE);
    assign full       = (state_q == S_DONE);
    assign word_rdy_o = (state_q == S_FILL);
    assign word_vld_o = (state_q == S_EVICT);
    assign word_o     = (state_q == S_EVICT) ? line_q[idx_q] : '0;
    // base_q has its low bits already cleared, so OR-ing in the word offset equals concatenation.
    assign addr_o     = active ? (base_q | (ADDR_W'(idx_q) << BOFF)) : '0;
    assign line_o     = line_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// tb/tb_cache_line_xfer.sv - directed vector bench for cache_line_xfer
module tb_cache_line_xfer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int WORDS  = 8;
    localparam int LW     = WORDS * DATA_W;

    logic              clk;
    logic              clr_n;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        crit_idx;
    logic [LW-1:0]     line_i;
    logic [DATA_W-1:0] word_i;
    logic              word_vld_i;
    logic              word_rdy_o;
    logic [DATA_W-1:0] word_o;
    logic              word_vld_o;
    logic              word_rdy_i;
    logic [ADDR_W-1:0] addr_o;
    logic [LW-1:0]     line_o;
    logic              full;
    logic              busy;

    int checks;
    int errors;

    cache_line_xfer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .crit_idx   (crit_idx),
        .line_i     (line_i),
        .word_i     (word_i),
        .word_vld_i (word_vld_i),
        .word_rdy_o (word_rdy_o),
        .word_o     (word_o),
        .word_vld_o (word_vld_o),
        .word_rdy_i (word_rdy_i),
        .addr_o     (addr_o),
        .line_o     (line_o),
        .full       (full),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          mode;
        logic [31:0] base;
        int          crit;
        int          gap;
        logic [31:0] seed;
        bit          repulse;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_val(input vec_t v, input int k);
        return v.mode ? v.seed + k : v.seed - k;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        int cyc;
        int eidx;
        logic [LW-1:0] exp_line;
        for (int k = 0; k < WORDS; k++) exp_line[k*DATA_W +: DATA_W] = word_val(v, k);
        @(negedge clk);
        start     = 1'b1;
        mode      = v.mode;
        base_addr = v.base;
        crit_idx  = 3'(v.crit);
        line_i    = v.mode ? exp_line : ~exp_line;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        cyc   = 0;
        while (n < WORDS && cyc < 200) begin
            eidx       = (v.crit + n) % WORDS;
            start      = v.repulse && cyc == 2;
            mode       = (v.repulse && cyc == 2) ? ~v.mode : v.mode;
            base_addr  = (v.repulse && cyc == 2) ? 32'h2000 : v.base;
            crit_idx   = (v.repulse && cyc == 2) ? 3'd6 : 3'(v.crit);
            word_vld_i = !v.mode && (cyc % v.gap == 0);
            word_rdy_i = v.mode && (cyc % v.gap == 0);
            word_i     = word_val(v, eidx);
            @(negedge clk);
            check({v.name, " addr_o"}, LW'(addr_o), LW'((v.base & ~32'h1F) | (eidx << 2)));
            check({v.name, " busy"}, LW'(busy), LW'(1));
            if (v.mode) begin
                check({v.name, " word_vld_o"}, LW'(word_vld_o), LW'(1));
                check({v.name, " word_o"}, LW'(word_o), LW'(word_val(v, eidx)));
            end else begin
                check({v.name, " word_rdy_o"}, LW'(word_rdy_o), LW'(1));
            end
            @(posedge clk);
            if (word_vld_i || word_rdy_i) n++;
            cyc++;
            #1;
            start = 1'b0;
        end
        word_vld_i = 1'b0;
        word_rdy_i = 1'b0;
        check({v.name, " handshakes"}, LW'(n), LW'(WORDS));
        @(negedge clk);
        check({v.name, " full"}, LW'(full), LW'(1));
        check({v.name, " cycles"}, LW'(cyc), LW'(v.exp_cycles));
        check({v.name, " addr_done"}, LW'(addr_o), LW'(0));
        check({v.name, " line_o"}, line_o, exp_line);
        @(negedge clk);
        check({v.name, " full_end"}, LW'(full), LW'(0));
        check({v.name, " busy_end"}, LW'(busy), LW'(0));
        check({v.name, " line_hold"}, line_o, exp_line);
    endtask

    initial begin
        int nfull;
        checks     = 0;
        errors     = 0;
        clr_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        base_addr  = '0;
        crit_idx   = '0;
        line_i     = '0;
        word_i     = '0;
        word_vld_i = 1'b0;
        word_rdy_i = 1'b0;

        vecs[0] = '{"fill_gap4",   1'b0, 32'h0000_1000, 0, 4, 32'hFFFF_FFFF, 1'b0, 29};
        vecs[1] = '{"fill_crit5",  1'b0, 32'h0000_1000, 5, 1, 32'h1111_0000, 1'b0, 8};
        vecs[2] = '{"evict_tog",   1'b1, 32'h0000_1000, 0, 2, 32'h0000_00A0, 1'b0, 15};
        vecs[3] = '{"evict_rep",   1'b1, 32'h0000_1004, 0, 1, 32'h0000_5000, 1'b1, 8};
        vecs[4] = '{"fill_crit7",  1'b0, 32'h0001_2345, 7, 3, 32'hC0DE_0000, 1'b0, 22};
        vecs[5] = '{"evict_top",   1'b1, 32'hFFFF_FFE0, 3, 1, 32'h7700_0000, 1'b0, 8};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", LW'(busy), LW'(0));
        clr_n = 1'b1;
        @(negedge clk);
        check("idle busy", LW'(busy), LW'(0));
        check("idle full", LW'(full), LW'(0));
        check("idle addr_o", LW'(addr_o), LW'(0));
        check("idle line_o", line_o, '0);
        check("idle word_rdy_o", LW'(word_rdy_o), LW'(0));

        // Reset asserted mid-FILL after three accepted words.
        start      = 1'b1;
        base_addr  = 32'h1000;
        @(posedge clk);
        #1;
        start      = 1'b0;
        word_vld_i = 1'b1;
        word_i     = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("mid_fill busy", LW'(busy), LW'(1));
        check("mid_fill line_o", LW'(line_o[DATA_W-1:0]), LW'(32'hDEAD_BEEF));
        clr_n = 1'b0;
        #1;
        check("rst busy async", LW'(busy), LW'(0));
        check("rst full async", LW'(full), LW'(0));
        check("rst word_rdy_o async", LW'(word_rdy_o), LW'(0));
        check("rst addr_o async", LW'(addr_o), LW'(0));
        check("rst line_o async", line_o, '0);
        word_vld_i = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Start held high across two FILLs.
        @(negedge clk);
        start      = 1'b1;
        mode       = 1'b0;
        base_addr  = 32'h1000;
        crit_idx   = 3'd2;
        word_vld_i = 1'b1;
        word_i     = 32'h1234_5678;
        @(posedge clk);
        nfull = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 10) start = 1'b0;
            if (full) nfull++;
            if (e == 8)  check("held full_1st", LW'(full), LW'(1));
            if (e == 9)  check("held idle_gap", LW'(busy), LW'(0));
            if (e == 10) check("held restart addr", LW'(addr_o), LW'(32'h1008));
            if (e == 18) check("held full_2nd", LW'(full), LW'(1));
        end
        word_vld_i = 1'b0;
        check("held full count", LW'(nfull), LW'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
